// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state encoding, byte-enable patterns and an access-size decoder.
package riscv_mem_pkg;

    // funct3 access size / signedness encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns for the data-memory bus
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DONE     = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } mem_size_e;

    // Access width implied by funct3; SZ_NONE marks an illegal encoding.
    function automatic mem_size_e f3_size(input logic [2:0] f3);
        mem_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            F3_W:        sz = SZ_WORD;
            default:     sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Load-data formatter: picks the addressed byte/half out of a 32-bit read
// word and sign- or zero-extends it according to funct3.
module mem_load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; illegal funct3 yields zero.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    result_o = rdata_i;
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Issues one valid/ready request per memory
// instruction, waits for read data (with an optional response timeout),
// formats loads, and stalls the pipeline until the access retires in DONE.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ld_q, ld_d;

    logic             access;
    logic             is_read;
    logic             bad;
    mem_size_e        size;
    logic [1:0]       addr_lo;
    logic [31:0]      fmt_data;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    // A read takes priority when both MemRead and MemWrite are set.
    assign access    = mem_MemRead | mem_MemWrite;
    assign is_read   = mem_MemRead;
    assign addr_lo   = mem_alu_result[1:0];
    assign size      = f3_size(mem_funct3);
    assign dmem_addr = {mem_alu_result[31:2], 2'b00};

    // The counter value after this WAIT_RSP cycle; reaching RSP_TIMEOUT
    // means that many response cycles have gone by empty.
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (RSP_TIMEOUT != 32'd0) && (cnt_inc == CNT_W'(RSP_TIMEOUT));

    mem_load_formatter u_fmt (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_lo),
        .funct3_i  (mem_funct3),
        .result_o  (fmt_data)
    );

    // Illegal funct3 or an address not aligned to the access size.
    always_comb begin
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            SZ_NONE: bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    // Store lane placement: replicate the data and enable the addressed bytes.
    always_comb begin
        st_be    = BE_WORD;
        st_wdata = mem_write_data;
        case (size)
            SZ_BYTE: begin
                st_be    = BE_BYTE << addr_lo;
                st_wdata = {4{mem_write_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                st_wdata = {2{mem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state and output decode; every output is forced low while reset is held.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ld_d           = ld_q;
        mem_stall      = 1'b0;
        mem_fault      = 1'b0;
        mem_read_data  = '0;
        dmem_req_valid = 1'b0;
        dmem_we        = 1'b0;
        dmem_be        = BE_NONE;
        dmem_wdata     = '0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (bad) begin
                        // Dropped without touching memory; the instruction flows on.
                        mem_fault = 1'b1;
                    end else begin
                        dmem_req_valid = 1'b1;
                        mem_stall      = 1'b1;
                        dmem_we        = ~is_read;
                        dmem_be        = is_read ? BE_WORD : st_be;
                        dmem_wdata     = is_read ? 32'd0 : st_wdata;
                        if (dmem_req_ready) begin
                            if (is_read) begin
                                state_d = WAIT_RSP;
                                cnt_d   = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            WAIT_RSP: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_inc;
                // A response in the timeout cycle still counts as a response.
                if (dmem_rsp_valid) begin
                    ld_d    = fmt_data;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    ld_d      = '0;
                    mem_fault = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                mem_read_data = ld_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!reset) begin
            mem_stall      = 1'b0;
            mem_fault      = 1'b0;
            mem_read_data  = '0;
            dmem_req_valid = 1'b0;
            dmem_we        = 1'b0;
            dmem_be        = BE_NONE;
            dmem_wdata     = '0;
        end
    end

    // State, timeout counter and captured load data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset
// sequences and randomized transactions against a behavioural model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        mem_fault;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cap = 32'd0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        bit          exp_bad;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    mem_access_unit #(.RSP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_stall      (mem_stall),
        .mem_fault      (mem_fault),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int rdy, input int rsp,
                                input bit bad, input logic [3:0] be,
                                input logic [31:0] wdat, input logic [31:0] data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_bad = bad; v.exp_be = be;
        v.exp_wdata = wdat; v.exp_data = data;
        return v;
    endfunction

    // Reference: derive expectations from access width, offset and signedness.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int nbytes;
        int off;
        bit sgn;
        bit legal;
        logic [31:0] mask;
        logic [31:0] val;
        r = v;
        off = int'(v.addr[1:0]);
        legal = 1'b1; sgn = 1'b0; nbytes = 4;
        case (v.f3)
            3'd0: begin nbytes = 1; sgn = 1'b1; end
            3'd1: begin nbytes = 2; sgn = 1'b1; end
            3'd2: nbytes = 4;
            3'd4: nbytes = 1;
            3'd5: nbytes = 2;
            default: legal = 1'b0;
        endcase
        r.exp_bad = !legal || ((off % nbytes) != 0);
        if (v.rd) begin
            r.exp_be    = 4'hF;
            r.exp_wdata = 32'd0;
        end else begin
            r.exp_be = 4'(((1 << nbytes) - 1) << off);
            if (nbytes == 1)      r.exp_wdata = v.wd[7:0] * 32'h01010101;
            else if (nbytes == 2) r.exp_wdata = v.wd[15:0] * 32'h00010001;
            else                  r.exp_wdata = v.wd;
        end
        if (nbytes == 4) begin
            val = v.rdata;
        end else begin
            mask = (nbytes == 1) ? 32'h000000FF : 32'h0000FFFF;
            val  = (v.rdata >> (8 * off)) & mask;
            if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
        end
        r.exp_data = (v.rsp_dly >= TMO) ? 32'd0 : val;
        return r;
    endfunction

    task automatic drive_idle(input bit stray);
        mem_MemRead    = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_funct3     = 3'd0;
        mem_alu_result = $urandom;
        mem_write_data = $urandom;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = stray;
        dmem_rdata     = $urandom;
    endtask

    task automatic idle_cycle(input bit stray, input string tag);
        @(posedge clk); #1;
        drive_idle(stray);
        @(negedge clk);
        chk({tag, ".idle_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".idle_fault"}, 32'(mem_fault), 32'd0);
        chk({tag, ".idle_valid"}, 32'(dmem_req_valid), 32'd0);
        chk({tag, ".idle_rdata"}, mem_read_data, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit is_wr;
        bit tmo;
        bit got;
        is_wr = v.wr && !v.rd;
        tmo = 1'b0;
        got = 1'b0;

        @(posedge clk); #1;
        mem_MemRead    = v.rd;
        mem_MemWrite   = v.wr;
        mem_funct3     = v.f3;
        mem_alu_result = v.addr;
        mem_write_data = v.wd;
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = v.exp_bad ? 1'b1 : (v.rdy_dly == 0);

        if (v.exp_bad) begin
            @(negedge clk);
            chk({tag, ".bad_fault"}, 32'(mem_fault), 32'd1);
            chk({tag, ".bad_stall"}, 32'(mem_stall), 32'd0);
            chk({tag, ".bad_valid"}, 32'(dmem_req_valid), 32'd0);
            chk({tag, ".bad_rdata"}, mem_read_data, 32'd0);
            idle_cycle(1'b0, tag);
            return;
        end

        for (int k = 0; k <= v.rdy_dly; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                dmem_req_ready = (k == v.rdy_dly);
            end
            @(negedge clk);
            chk({tag, ".req_valid"}, 32'(dmem_req_valid), 32'd1);
            chk({tag, ".req_stall"}, 32'(mem_stall), 32'd1);
            chk({tag, ".req_fault"}, 32'(mem_fault), 32'd0);
            chk({tag, ".req_we"}, 32'(dmem_we), 32'(is_wr));
            chk({tag, ".req_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            chk({tag, ".req_be"}, 32'(dmem_be), 32'(v.exp_be));
            if (is_wr) chk({tag, ".req_wdata"}, dmem_wdata, v.exp_wdata);
        end

        if (!is_wr) begin
            for (int j = 1; j <= TMO; j++) begin
                @(posedge clk); #1;
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = (j == v.rsp_dly + 1);
                dmem_rdata     = dmem_rsp_valid ? v.rdata : $urandom;
                got = dmem_rsp_valid;
                tmo = (j == TMO) && !got;
                @(negedge clk);
                chk({tag, ".wait_stall"}, 32'(mem_stall), 32'd1);
                chk({tag, ".wait_valid"}, 32'(dmem_req_valid), 32'd0);
                chk({tag, ".wait_fault"}, 32'(mem_fault), 32'(tmo));
                if (got || tmo) break;
            end
            cap = tmo ? 32'd0 : v.exp_data;
        end

        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = $urandom;
        @(negedge clk);
        chk({tag, ".done_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".done_fault"}, 32'(mem_fault), 32'd0);
        chk({tag, ".done_valid"}, 32'(dmem_req_valid), 32'd0);
        chk({tag, ".done_rdata"}, mem_read_data, cap);
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_funct3 = 3'b010;
        mem_alu_result = 32'h100; mem_write_data = 32'h0;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst.rdata", mem_read_data, 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.fault", 32'(mem_fault), 32'd0);
        chk("rst.valid", 32'(dmem_req_valid), 32'd0);
        chk("rst.we",    32'(dmem_we), 32'd0);
        chk("rst.be",    32'(dmem_be), 32'd0);
        mem_funct3 = 3'b011;
        #1;
        chk("rst.bad_fault", 32'(mem_fault), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle(1'b0);
        idle_cycle(1'b0, "post_rst");

        // ---------------- directed vector table ----------------
        tbl.push_back(mk(1,0,3'b010,32'h100,0,32'hDEADBEEF,0,0,0,4'hF,0,32'hDEADBEEF));
        tbl.push_back(mk(1,0,3'b000,32'h103,0,32'h80FF1234,0,0,0,4'hF,0,32'hFFFFFF80));
        tbl.push_back(mk(1,0,3'b100,32'h103,0,32'h80FF1234,0,1,0,4'hF,0,32'h00000080));
        tbl.push_back(mk(1,0,3'b101,32'h102,0,32'h80FF1234,1,0,0,4'hF,0,32'h000080FF));
        tbl.push_back(mk(1,0,3'b001,32'h102,0,32'h80FF1234,0,0,0,4'hF,0,32'hFFFF80FF));
        tbl.push_back(mk(1,0,3'b000,32'h100,0,32'h80FF1234,0,2,0,4'hF,0,32'h00000034));
        tbl.push_back(mk(0,1,3'b000,32'h201,32'h000000AB,0,3,0,0,4'b0010,32'hABABABAB,0));
        tbl.push_back(mk(0,1,3'b001,32'h202,32'h1234CAFE,0,0,0,0,4'b1100,32'hCAFECAFE,0));
        tbl.push_back(mk(0,1,3'b010,32'h204,32'h12345678,0,2,0,0,4'b1111,32'h12345678,0));
        tbl.push_back(mk(0,1,3'b001,32'h203,32'h00001111,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,3'b011,32'h100,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,3'b010,32'h102,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,3'b110,32'h100,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,3'b111,32'h100,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,3'b010,32'h108,0,32'hCAFEF00D,0,4,0,4'hF,0,32'h00000000));
        tbl.push_back(mk(1,0,3'b010,32'h10C,0,32'h5A5A0001,0,3,0,4'hF,0,32'h5A5A0001));
        tbl.push_back(mk(1,1,3'b010,32'h300,32'hFFFFFFFF,32'h01020304,0,0,0,4'hF,0,32'h01020304));
        tbl.push_back(mk(1,0,3'b101,32'h100,0,32'h0000F00D,0,0,0,4'hF,0,32'h0000F00D));
        tbl.push_back(mk(1,0,3'b001,32'h100,0,32'h0000F00D,0,0,0,4'hF,0,32'hFFFFF00D));
        tbl.push_back(mk(0,1,3'b000,32'h203,32'h0000005C,2,0,0,0,4'b1000,32'h5C5C5C5C,0));

        foreach (tbl[i]) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end
        idle_cycle(1'b1, "tbl_end");

        // ---------------- reset in the middle of WAIT_RSP ----------------
        @(posedge clk); #1;
        mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_funct3 = 3'b010;
        mem_alu_result = 32'h400; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("mid.req_valid", 32'(dmem_req_valid), 32'd1);
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("mid.wait_stall", 32'(mem_stall), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid.rst_valid", 32'(dmem_req_valid), 32'd0);
        chk("mid.rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle(1'b1);
        dmem_rdata = 32'h11111111;
        @(negedge clk);
        chk("mid.stray_stall", 32'(mem_stall), 32'd0);
        chk("mid.stray_rdata", mem_read_data, 32'd0);
        idle_cycle(1'b0, "mid.after");
        cap = 32'd0;
        run_txn(mk(1,0,3'b010,32'h400,0,32'h600DF00D,0,0,0,4'hF,0,32'h600DF00D), "mid.lw");

        // ---------------- randomized transactions ----------------
        for (int i = 0; i < 200; i++) begin
            vec_t v;
            int sel;
            logic [2:0] f3_all [8];
            f3_all = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
            sel = $urandom_range(0, 3);
            v.rd = (sel != 1);
            v.wr = (sel == 1) || (sel == 3);
            if (v.wr && !v.rd) begin
                case ($urandom_range(0, 6))
                    0, 1:    v.f3 = 3'd0;
                    2, 3:    v.f3 = 3'd1;
                    4:       v.f3 = 3'd2;
                    5:       v.f3 = 3'd3;
                    default: v.f3 = 3'd7;
                endcase
            end else begin
                v.f3 = f3_all[$urandom_range(0, 7)];
            end
            v.addr = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (v.f3[1:0] == 2'd1) v.addr[0] = 1'b0;
                if (v.f3[1:0] == 2'd2) v.addr[1:0] = 2'b00;
            end
            v.wd      = $urandom;
            v.rdata   = $urandom;
            v.rdy_dly = $urandom_range(0, 3);
            v.rsp_dly = $urandom_range(0, 5);
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
